cmp_slice_seq_ctrl: RTL and testbench
=====================================

// Module: cmp_slice_seq_ctrl
// PURPOSE
//  Sequencer that drives the shared 2-bit equality comparator (in1..in4 -> out1) to
//  compare two WIDTH-bit operands, one 2-bit slice per clock, MSB slice first.
//  Sits between a requester (valid/ready command) and the single comparator
//  instance. Returns a registered equal/not-equal result with a cycle count.
// PARAMETERS
//  WIDTH     8   operand width; even, >= 2; NSLICE = WIDTH/2
//  CNT_W     3   width of res_cycles; must hold NSLICE ($clog2(NSLICE+1))
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous active-high reset
//  start_valid  in   1      command valid
//  start_ready  out  1      command ready; high only in IDLE
//  op_a         in   WIDTH  operand A; sampled on the accept edge
//  op_b         in   WIDTH  operand B; sampled on the accept edge
//  cmp_in1      out  1      A slice bit 1 (MSB of slice) to comparator
//  cmp_in2      out  1      A slice bit 0
//  cmp_in3      out  1      B slice bit 1
//  cmp_in4      out  1      B slice bit 0
//  cmp_out1     in   1      comparator result; 1 = slices equal (combinational)
//  busy         out  1      high in RUN or DONE
//  res_valid    out  1      result valid; high only in DONE
//  res_ready    in   1      result consumed
//  res_eq       out  1      1 = op_a == op_b
//  res_cycles   out  CNT_W  number of RUN cycles used
// BEHAVIOUR
//  - Clock/reset: one clock. Reset is synchronous and active-high.
//  - Reset (rst=1 at an edge): state=IDLE; res_valid=0; res_eq=0;
//    res_cycles=0; busy=0; cmp_in1..4=0; the in-flight operation is
//    discarded and produces no result.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: start_ready=1. On start_valid&&start_ready at an edge: latch
//    op_a/op_b; idx=NSLICE-1; eq_acc=1; res_cycles=0; go to RUN.
//  - RUN: cmp_in1,cmp_in2 = A[2*idx+1], A[2*idx]; cmp_in3,cmp_in4 =
//    B[2*idx+1], B[2*idx]. cmp_out1 is sampled at the end of the same cycle.
//    At each edge: eq_acc &= cmp_out1; res_cycles += 1. If idx==0, go to
//    DONE. Otherwise idx -= 1.
//  - DONE: res_valid=1; res_eq=eq_acc; res_cycles held. All result outputs
//    are stable until an edge with res_ready=1, which moves the FSM to IDLE.
//    Any new command is accepted no earlier than the following cycle.
//  - cmp_in1..4 are 0 in IDLE and DONE. All outputs come from registers or
//    state decode only; there is no combinational path from any input to
//    any output.
//  - Latency without early exit: res_valid is high exactly NSLICE cycles
//    after the accept edge.
//  - start_valid in RUN or DONE: ignored, because start_ready=0. op_a/op_b
//    changes after the accept edge have no effect.
//  - res_ready in IDLE or RUN: ignored.
//  - WIDTH=2: one RUN cycle.
// CONFIGURATION
//  CMP_EARLY_EXIT_EN defined: in RUN, an edge that samples cmp_out1=0 goes
//    straight to DONE with res_eq=0, and res_cycles counts that cycle
//    (range 1..NSLICE).
//  CMP_EARLY_EXIT_EN undefined: all NSLICE slices are always compared;
//    res_cycles=NSLICE for every result. res_eq is identical in both builds.
// TESTING  (WIDTH=8; bench models the comparator as out1 = ({in1,in2}=={in3,in4}))
//  1. A=8'hA5, B=8'hA5 -> res_valid 4 cycles after accept, res_eq=1,
//     res_cycles=4; cmp_in slices in order 2,2,1,1 per side.
//  2. A=8'hA5, B=8'h25 (MSB slice differs) -> res_eq=0; res_cycles=4
//     without CMP_EARLY_EXIT_EN, res_cycles=1 with it.
//  3. A=8'hA5, B=8'hA4 (LSB slice differs) -> res_eq=0, res_cycles=4 in
//     both builds.
//  4. res_ready held low 3 cycles in DONE -> res_valid/res_eq/res_cycles
//     stable; res_ready=1 -> IDLE next cycle and start_ready=1.
//  5. start_valid pulsed with new operands during RUN -> not accepted;
//     result reflects the original operands.
//  6. rst=1 during the 2nd RUN cycle -> next cycle IDLE, res_valid=0,
//     cmp_in1..4=0, and no result is ever presented for that command.

Source files
------------

// File: rtl/cmp_slice_seq_ctrl.sv
// Sequencer that walks two WIDTH-bit operands through a shared 2-bit equality comparator,
// MSB slice first. Optional CMP_EARLY_EXIT_EN ends the run on the first unequal slice.
module cmp_slice_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             cmp_in1,
    output logic             cmp_in2,
    output logic             cmp_in3,
    output logic             cmp_in4,
    input  logic             cmp_out1,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_eq,
    output logic [CNT_W-1:0] res_cycles
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             eq_acc_q, eq_acc_d;
    logic             res_eq_q, res_eq_d;
    logic [CNT_W-1:0] res_cycles_q, res_cycles_d;
    logic             last_slice;
    logic [1:0]       a_sl, b_sl;

    // Slice select uses constant part-selects so the index never widens.
    always_comb begin
        a_sl = 2'b00;
        b_sl = 2'b00;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl = a_q[2*i +: 2];
                b_sl = b_q[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        eq_acc_d     = eq_acc_q;
        res_eq_d     = res_eq_q;
        res_cycles_d = res_cycles_q;
        last_slice   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d          = op_a;
                    b_d          = op_b;
                    idx_d        = IDX_W'(NSLICE - 1);
                    eq_acc_d     = 1'b1;
                    res_cycles_d = '0;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                eq_acc_d     = eq_acc_q & cmp_out1;
                res_cycles_d = res_cycles_q + CNT_W'(1);
                last_slice   = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
                if (!cmp_out1) last_slice = 1'b1;
`endif
                if (last_slice) begin
                    res_eq_d = eq_acc_d;
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            eq_acc_q     <= 1'b1;
            res_eq_q     <= 1'b0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            eq_acc_q     <= eq_acc_d;
            res_eq_q     <= res_eq_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    // Operand holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign res_eq      = res_eq_q;
    assign res_cycles  = res_cycles_q;
    assign cmp_in1     = (state_q == S_RUN) & a_sl[1];
    assign cmp_in2     = (state_q == S_RUN) & a_sl[0];
    assign cmp_in3     = (state_q == S_RUN) & b_sl[1];
    assign cmp_in4     = (state_q == S_RUN) & b_sl[0];

endmodule

// File: tb/tb_cmp_slice_seq_ctrl.sv
// Directed bench for cmp_slice_seq_ctrl (WIDTH=8) with a behavioural 2-bit comparator.
module tb_cmp_slice_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] op_a, op_b;
    logic       cmp_in1, cmp_in2, cmp_in3, cmp_in4;
    logic       cmp_out1;
    logic       busy, res_valid, res_ready, res_eq;
    logic [2:0] res_cycles;

    int checks   = 0;
    int failures = 0;

`ifdef CMP_EARLY_EXIT_EN
    localparam int EE = 1;
`else
    localparam int EE = 0;
`endif

    always #5 clk = ~clk;

    assign cmp_out1 = ({cmp_in1, cmp_in2} == {cmp_in3, cmp_in4});

    cmp_slice_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .cmp_in1    (cmp_in1),
        .cmp_in2    (cmp_in2),
        .cmp_in3    (cmp_in3),
        .cmp_in4    (cmp_in4),
        .cmp_out1   (cmp_out1),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_eq     (res_eq),
        .res_cycles (res_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one command, follow it slice by slice, hold DONE, then release.
    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic exp_eq, input int exp_cyc,
                          input int hold, input bit poke);
        logic [7:0] ea, eb;
        ea = a;
        eb = b;
        op_a = a;
        op_b = b;
        start_valid = 1'b1;
        chk("idle_ready", {31'd0, start_ready}, 1);
        tick();
        start_valid = 1'b0;
        for (int c = 1; c <= exp_cyc; c++) begin
            chk("run_busy", {31'd0, busy}, 1);
            chk("run_valid", {31'd0, res_valid}, 0);
            chk("run_ready", {31'd0, start_ready}, 0);
            chk("run_a_slice", {30'd0, cmp_in1, cmp_in2}, {30'd0, ea[2*(4-c) +: 2]});
            chk("run_b_slice", {30'd0, cmp_in3, cmp_in4}, {30'd0, eb[2*(4-c) +: 2]});
            if (poke && c == 2) begin
                start_valid = 1'b1;
                op_a = 8'h00;
                op_b = 8'hFF;
            end
            tick();
        end
        start_valid = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk("done_valid", {31'd0, res_valid}, 1);
            chk("done_eq", {31'd0, res_eq}, {31'd0, exp_eq});
            chk("done_cycles", {29'd0, res_cycles}, exp_cyc);
            chk("done_busy", {31'd0, busy}, 1);
            chk("done_cmp", {28'd0, cmp_in1, cmp_in2, cmp_in3, cmp_in4}, 0);
            if (h < hold) tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("rel_ready", {31'd0, start_ready}, 1);
        chk("rel_valid", {31'd0, res_valid}, 0);
        chk("rel_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        op_a = 8'h00;
        op_b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, start_ready}, 1);
        chk("rst_valid", {31'd0, res_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_eq", {31'd0, res_eq}, 0);
        chk("rst_cycles", {29'd0, res_cycles}, 0);
        chk("rst_cmp", {28'd0, cmp_in1, cmp_in2, cmp_in3, cmp_in4}, 0);

        // Equal operands, with a 3-cycle hold in DONE
        do_cmd(8'hA5, 8'hA5, 1'b1, 4, 3, 1'b0);
        // MSB slice differs
        do_cmd(8'hA5, 8'h25, 1'b0, (EE != 0) ? 1 : 4, 0, 1'b0);
        // LSB slice differs
        do_cmd(8'hA5, 8'hA4, 1'b0, 4, 0, 1'b0);
        // Middle slice differs, idle response between commands
        tick();
        do_cmd(8'h3C, 8'h34, 1'b0, (EE != 0) ? 3 : 4, 1, 1'b0);
        // New command offered during RUN must be ignored
        do_cmd(8'hA5, 8'hA5, 1'b1, 4, 0, 1'b1);
        chk("poke_idle_ready", {31'd0, start_ready}, 1);

        // Reset in the second RUN cycle discards the command
        op_a = 8'h5A;
        op_b = 8'h5A;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, start_ready}, 1);
        chk("mid_rst_valid", {31'd0, res_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_cmp", {28'd0, cmp_in1, cmp_in2, cmp_in3, cmp_in4}, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_no_result", {31'd0, res_valid}, 0);
        end

        // Fresh command after reset still works
        do_cmd(8'hFF, 8'hFF, 1'b1, 4, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
